// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM sub-controller port between SPART (0), VGA (1) and DMEM (2).
// Loads the winner's address window, then holds the grant until done, request drop or hold limit.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int MAX_HOLD = 1024
) (
  input  logic                  clk_100_pll,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [2:0]            done,
  input  logic [3*ADDR_W-1:0]   req_start_addr,
  input  logic [3*ADDR_W-1:0]   req_end_addr,
  output logic [2:0]            grant,
  output logic [2:0]            busy,
  output logic [1:0]            owner,
  output logic [ADDR_W-1:0]     sdram_start,
  output logic [ADDR_W-1:0]     sdram_end,
  output logic [ADDR_W:0]       sdram_len,
  output logic                  sdram_load,
  output logic                  timeout,
  output logic                  addr_err
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OWN, S_RELEASE} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_ptr, w_ptr_nx;
  logic [1:0]        r_owner;
  logic [HW-1:0]     r_hold;
  logic [ADDR_W-1:0] r_start, r_end;
  logic [ADDR_W:0]   r_len;
  logic              r_timeout, r_addr_err;

  logic              w_found, w_valid, w_take, w_timeout, w_addr_err;
  logic [1:0]        w_cand;
  logic [ADDR_W-1:0] w_cs, w_ce;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Candidate search: ptr, ptr+1, ptr+2 (mod 3), first requester wins.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_cand  = r_ptr;
    idx     = r_ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_cand  = idx;
      end
      idx = inc3(idx);
    end
  end

  always_comb begin
    w_cs = req_start_addr[0 +: ADDR_W];
    w_ce = req_end_addr[0 +: ADDR_W];
    case (w_cand)
      2'd1: begin
        w_cs = req_start_addr[ADDR_W +: ADDR_W];
        w_ce = req_end_addr[ADDR_W +: ADDR_W];
      end
      2'd2: begin
        w_cs = req_start_addr[2*ADDR_W +: ADDR_W];
        w_ce = req_end_addr[2*ADDR_W +: ADDR_W];
      end
      default: ;
    endcase
    w_valid = (w_ce >= w_cs);
  end

  always_comb begin
    w_next     = r_state;
    w_ptr_nx   = r_ptr;
    w_take     = 1'b0;
    w_timeout  = 1'b0;
    w_addr_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          if (w_valid) begin
            w_take = 1'b1;
            w_next = S_LOAD;
          end else begin
            w_addr_err = 1'b1;
            w_ptr_nx   = inc3(w_cand);
          end
        end
      end
      S_LOAD: w_next = S_OWN;
      S_OWN: begin
        if (done[r_owner] || !req[r_owner]) begin
          w_next = S_RELEASE;
        end else if ((MAX_HOLD != 0) && (r_hold == HOLD_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_ptr_nx = inc3(r_owner);
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100_pll or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_100_pll or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_hold     <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_len      <= '0;
      r_timeout  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_nx;
      r_timeout  <= w_timeout;
      r_addr_err <= w_addr_err;
      r_hold     <= (r_state == S_OWN) ? r_hold + 1'b1 : '0;
      if (w_take) begin
        r_owner <= w_cand;
        r_start <= w_cs;
        r_end   <= w_ce;
        r_len   <= {1'b0, w_ce} - {1'b0, w_cs} + (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    grant = '0;
    busy  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      grant[i] = (r_state == S_OWN) && (r_owner == 2'(i));
      busy[i]  = (r_state != S_IDLE) && !((r_state == S_OWN) && (r_owner == 2'(i)));
    end
  end

  assign owner       = r_owner;
  assign sdram_start = r_start;
  assign sdram_end   = r_end;
  assign sdram_len   = r_len;
  assign sdram_load  = (r_state == S_LOAD);
  assign timeout     = r_timeout;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: handshake latency, round-robin order, hold limit,
// address rejection, simultaneous release causes and length boundaries.
module tb_sdram_port_arbiter;

  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      done = '0;
  logic [3*AW-1:0] st = '0;
  logic [3*AW-1:0] en = '0;
  logic [2:0]      grant, busy;
  logic [1:0]      owner;
  logic [AW-1:0]   sdram_start, sdram_end;
  logic [AW:0]     sdram_len;
  logic            sdram_load, timeout, addr_err;

  int tests = 0;
  int fails = 0;

  sdram_port_arbiter #(.ADDR_W(AW), .MAX_HOLD(16)) dut (
    .clk_100_pll(clk), .rst_n(rst_n), .req(req), .done(done),
    .req_start_addr(st), .req_end_addr(en),
    .grant(grant), .busy(busy), .owner(owner),
    .sdram_start(sdram_start), .sdram_end(sdram_end), .sdram_len(sdram_len),
    .sdram_load(sdram_load), .timeout(timeout), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int i, input logic [AW-1:0] s, input logic [AW-1:0] e);
    st[i*AW +: AW] = s;
    en[i*AW +: AW] = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  exp_g  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0]  exp_o  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [12:0] exp_l  [4] = '{13'h040, 13'h100, 13'h010, 13'h040};
    int cnt;

    // reset state
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", sdram_load, 0);
    chk("rst_owner", owner, 0);
    chk("rst_len", sdram_len, 0);
    rst_n = 1'b1;

    // single SPART transfer
    set_win(0, 12'h010, 12'h04F);
    set_win(1, 12'h200, 12'h2FF);
    set_win(2, 12'h300, 12'h30F);
    req = 3'b001;
    tick();
    chk("t2_load", sdram_load, 1);
    chk("t2_len", sdram_len, 13'h040);
    chk("t2_start", sdram_start, 12'h010);
    chk("t2_end", sdram_end, 12'h04F);
    chk("t2_grant_load", grant, 0);
    chk("t2_busy_load", busy, 3'b111);
    tick();
    chk("t2_grant", grant, 3'b001);
    chk("t2_busy_own", busy, 3'b110);
    chk("t2_load_off", sdram_load, 0);
    done = 3'b001;
    tick();
    chk("t2_rel_grant", grant, 0);
    chk("t2_rel_busy", busy, 3'b111);
    done = 3'b000; req = 3'b000;
    tick();
    chk("t2_idle_busy", busy, 0);

    // async reset while VGA owns the port
    req = 3'b010;
    tick();
    chk("rr_vga_owner", owner, 1);
    tick();
    chk("mr_grant_pre", grant, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_grant", grant, 0);
    chk("mr_busy", busy, 0);
    chk("mr_owner", owner, 0);
    req = 3'b000;
    tick();
    rst_n = 1'b1;

    // all three requesting: round-robin from SPART
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t3_load_%0d", k), sdram_load, 1);
      chk($sformatf("t3_owner_%0d", k), owner, exp_o[k]);
      chk($sformatf("t3_len_%0d", k), sdram_len, exp_l[k]);
      tick();
      chk($sformatf("t3_grant_%0d", k), grant, exp_g[k]);
      chk($sformatf("t3_busy_%0d", k), busy, ~exp_g[k] & 3'b111);
      repeat (3) begin
        tick();
        chk($sformatf("t3_hold_%0d", k), grant, exp_g[k]);
      end
      done = exp_g[k];
      tick();
      chk($sformatf("t3_rel_%0d", k), grant, 0);
      done = 3'b000;
      tick();
      chk($sformatf("t3_idle_%0d", k), busy, 0);
    end
    req = 3'b000;

    // hold limit: VGA never finishes
    req = 3'b110;
    tick();
    chk("t4_owner_vga", owner, 1);
    tick();
    cnt = 0;
    while (grant === 3'b010 && cnt < 40) begin
      cnt++;
      chk("t4_no_early_to", timeout, 0);
      tick();
    end
    chk("t4_hold_cycles", cnt, 16);
    chk("t4_timeout", timeout, 1);
    chk("t4_rel_grant", grant, 0);
    tick();
    chk("t4_timeout_off", timeout, 0);
    tick();
    chk("t4_owner_dmem", owner, 2);
    tick();
    chk("t4_grant_dmem", grant, 3'b100);
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();

    // non-owner done ignored; owner drops req and pulses done together
    req = 3'b010;
    tick(); tick();
    chk("t6_grant", grant, 3'b010);
    done = 3'b101;
    tick();
    chk("t6_nonowner_done", grant, 3'b010);
    done = 3'b010; req = 3'b000;
    tick();
    chk("t6_rel_grant", grant, 0);
    chk("t6_rel_busy", busy, 3'b111);
    done = 3'b000;
    tick();
    chk("t6_idle_busy", busy, 0);
    tick();
    chk("t6_single_rel_busy", busy, 0);
    chk("t6_single_rel_load", sdram_load, 0);

    // inverted DMEM window rejected, SPART served next
    set_win(2, 12'h100, 12'h0FF);
    set_win(0, 12'h020, 12'h02F);
    req = 3'b101;
    tick();
    chk("t5_addr_err", addr_err, 1);
    chk("t5_no_load", sdram_load, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_start_kept", sdram_start, 12'h200);
    tick();
    chk("t5_load", sdram_load, 1);
    chk("t5_owner", owner, 0);
    chk("t5_err_off", addr_err, 0);
    chk("t5_len", sdram_len, 13'h010);
    tick();
    chk("t5_grant", grant, 3'b001);
    req = 3'b000;
    tick(); tick();

    // length boundaries: full window and single word
    set_win(0, 12'h000, 12'hFFF);
    req = 3'b001;
    tick();
    chk("b_len_full", sdram_len, 13'h1000);
    tick();
    req = 3'b000;
    tick(); tick();
    chk("b_len_held", sdram_len, 13'h1000);
    set_win(0, 12'h055, 12'h055);
    req = 3'b001;
    tick();
    chk("b_len_one", sdram_len, 13'h0001);
    tick();
    req = 3'b000;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
